// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default widths, the hardwired-zero
// index and the requester ids used by the writeback arbiter.
package regfile_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; prio moves only when both inputs
// request in the same cycle and a grant is issued.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       hold,
   output logic [1:0] gnt
);

   req_id_e prio;

   logic contended;
   assign contended = ~hold & req[0] & req[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio <= REQ_A;
      end else if (contended) begin
         prio <= (prio == REQ_A) ? REQ_B : REQ_A;
      end
   end

   always_comb begin
      gnt = 2'b00;
      if (!hold) begin
         if (&req) begin
            gnt = (prio == REQ_A) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

endmodule

// File: rtl/regwrite_arbiter.sv
// Writeback arbiter for the register file write port: round-robin grant,
// one registered output stage, register-0 discard and a refusal counter.
module regwrite_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              rf_hold,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic [1:0]        gnt;
   logic              granted;
   logic              refused;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({b_valid, a_valid}),
      .hold  (rf_hold),
      .gnt   (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];
   assign granted = |gnt;

   assign sel_addr = gnt[0] ? a_addr : b_addr;
   assign sel_data = gnt[0] ? a_data : b_data;

   assign refused = (a_valid & ~a_ready) | (b_valid & ~b_ready);

   // Register-0 writes complete the handshake but never assert the enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
      end else if (granted) begin
         rf_wr_en   <= (sel_addr != ADDR_W'(REG_ZERO));
         rf_wr_addr <= sel_addr;
         rf_wr_data <= sel_data;
      end else begin
         rf_wr_en   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         conflict_cnt <= '0;
      end else if (refused && (conflict_cnt != {CNT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter; a second narrow-counter instance
// exercises counter saturation.
module tb_regwrite_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid, rf_hold;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic [15:0] conflict_cnt;

   logic        s_a_ready, s_b_ready, s_wr_en;
   logic [4:0]  s_wr_addr;
   logic [31:0] s_wr_data;
   logic [1:0]  s_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regwrite_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .a_valid      (a_valid),
      .a_addr       (a_addr),
      .a_data       (a_data),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_addr       (b_addr),
      .b_data       (b_data),
      .b_ready      (b_ready),
      .rf_hold      (rf_hold),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_data   (rf_wr_data),
      .conflict_cnt (conflict_cnt)
   );

   regwrite_arbiter #(.CNT_W(2)) dut_sat (
      .clk          (clk),
      .reset        (reset),
      .a_valid      (a_valid),
      .a_addr       (a_addr),
      .a_data       (a_data),
      .a_ready      (s_a_ready),
      .b_valid      (b_valid),
      .b_addr       (b_addr),
      .b_data       (b_data),
      .b_ready      (s_b_ready),
      .rf_hold      (rf_hold),
      .rf_wr_en     (s_wr_en),
      .rf_wr_addr   (s_wr_addr),
      .rf_wr_data   (s_wr_data),
      .conflict_cnt (s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset   = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      rf_hold = 1'b0;
      step(); step();
      chk("rst_en",   32'(rf_wr_en),     32'd0);
      chk("rst_addr", 32'(rf_wr_addr),   32'd0);
      chk("rst_data", rf_wr_data,        32'd0);
      chk("rst_cnt",  32'(conflict_cnt), 32'd0);
      reset = 1'b1;

      // A alone, first cycle out of reset
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
      settle();
      chk("a_only_ardy", 32'(a_ready), 32'd1);
      chk("a_only_brdy", 32'(b_ready), 32'd0);
      step();
      a_valid = 1'b0;
      chk("a_only_en",   32'(rf_wr_en),   32'd1);
      chk("a_only_addr", 32'(rf_wr_addr), 32'd5);
      chk("a_only_data", rf_wr_data,      32'hDEADBEEF);
      step();
      chk("a_only_en_off",  32'(rf_wr_en),   32'd0);
      chk("a_only_addr_hd", 32'(rf_wr_addr), 32'd5);
      chk("a_only_cnt",     32'(conflict_cnt), 32'd0);

      // Both valid for 4 cycles: A, B, A, B
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rr_ardy", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_brdy", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         step();
         chk("rr_en",   32'(rf_wr_en),   32'd1);
         chk("rr_addr", 32'(rf_wr_addr), (i % 2 == 0) ? 32'd1 : 32'd2);
         chk("rr_data", rf_wr_data,      (i % 2 == 0) ? 32'h11 : 32'h22);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      chk("rr_cnt", 32'(conflict_cnt), 32'd4);

      // B writes register 0
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
      settle();
      chk("r0_brdy", 32'(b_ready), 32'd1);
      step();
      b_valid = 1'b0;
      chk("r0_en",   32'(rf_wr_en),   32'd0);
      chk("r0_addr", 32'(rf_wr_addr), 32'd0);
      chk("r0_data", rf_wr_data,      32'hFFFFFFFF);
      chk("r0_cnt",  32'(conflict_cnt), 32'd4);

      // Hold for 3 cycles with A pending
      rf_hold = 1'b1;
      a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("hold_ardy", 32'(a_ready), 32'd0);
         step();
         chk("hold_en", 32'(rf_wr_en), 32'd0);
      end
      chk("hold_cnt", 32'(conflict_cnt), 32'd7);
      rf_hold = 1'b0;
      settle();
      chk("rel_ardy", 32'(a_ready), 32'd1);
      step();
      a_valid = 1'b0;
      chk("rel_en",   32'(rf_wr_en),   32'd1);
      chk("rel_addr", 32'(rf_wr_addr), 32'd7);
      chk("rel_cnt",  32'(conflict_cnt), 32'd7);

      // Contended grant to A (prio -> B), then async reset mid-cycle
      a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
      b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hAA;
      settle();
      chk("pre_rst_ardy", 32'(a_ready), 32'd1);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      chk("pre_rst_en", 32'(rf_wr_en), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_en",   32'(rf_wr_en),     32'd0);
      chk("arst_addr", 32'(rf_wr_addr),   32'd0);
      chk("arst_cnt",  32'(conflict_cnt), 32'd0);
      step();
      reset = 1'b1;

      // prio must be back at A
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
      b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
      settle();
      chk("post_rst_ardy", 32'(a_ready), 32'd1);
      chk("post_rst_brdy", 32'(b_ready), 32'd0);
      step();
      chk("post_rst_addr", 32'(rf_wr_addr), 32'd3);

      // Saturation on the 2-bit counter instance
      for (int i = 0; i < 4; i++) step();
      a_valid = 1'b0; b_valid = 1'b0;
      chk("sat_cnt",  32'(s_cnt),        32'd3);
      chk("main_cnt", 32'(conflict_cnt), 32'd5);
      step();
      chk("sat_hold", 32'(s_cnt), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
